// File: rtl/flipper_bank.sv
// flipper_bank: WIDTH independent channels with synchronised inputs, each in a
// run-time mode (pass, invert, toggle-on-edge, blink), configured over valid/ready.
module flipper_bank #(
    parameter int WIDTH     = 8,
    parameter int BLINK_DIV = 50000,
    parameter int DIV_W     = 16,
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_true,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_chan,
    input  logic [1:0]       cfg_mode,
    output logic             cfg_err,
    output logic [WIDTH-1:0] out_inv
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] tgl_r;
    mode_e            mode_r [WIDTH];
    logic [DIV_W-1:0] div_r;

    logic             tick_s;
    logic             xfer_s;
    logic             chan_bad_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] wr_hit_s;
    logic [WIDTH-1:0] tgl_upd_s;
    logic [WIDTH-1:0] tgl_next_s;
    logic [WIDTH-1:0] out_next_s;

    assign tick_s     = (div_r == DIV_W'(BLINK_DIV - 1));
    assign xfer_s     = cfg_valid & cfg_ready;
    assign chan_bad_s = ({{(32-CW){1'b0}}, cfg_chan} >= 32'(WIDTH));
    assign rise_s     = sync_r & ~prev_r;

    // Per-channel next toggle state and next output; a config write clears t.
    always_comb begin
        wr_hit_s   = {WIDTH{1'b0}};
        tgl_upd_s  = {WIDTH{1'b0}};
        tgl_next_s = {WIDTH{1'b0}};
        out_next_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            wr_hit_s[i] = xfer_s && (cfg_chan == CW'(i));
            case (mode_r[i])
                MODE_TOGGLE: tgl_upd_s[i] = tgl_r[i] ^ rise_s[i];
                MODE_BLINK:  tgl_upd_s[i] = sync_r[i] ? (tgl_r[i] ^ tick_s) : 1'b0;
                default:     tgl_upd_s[i] = tgl_r[i];
            endcase
            tgl_next_s[i] = wr_hit_s[i] ? 1'b0 : tgl_upd_s[i];
            case (mode_r[i])
                MODE_PASS:   out_next_s[i] = sync_r[i];
                MODE_INVERT: out_next_s[i] = ~sync_r[i];
                default:     out_next_s[i] = tgl_next_s[i];
            endcase
        end
    end

    // Synchroniser, edge history, channel state, prescaler and config port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r    <= {WIDTH{1'b0}};
            sync_r    <= {WIDTH{1'b0}};
            prev_r    <= {WIDTH{1'b0}};
            tgl_r     <= {WIDTH{1'b0}};
            out_inv   <= {WIDTH{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                mode_r[i] <= MODE_INVERT;
            end
        end else begin
            meta_r    <= in_true;
            sync_r    <= meta_r;
            prev_r    <= sync_r;
            tgl_r     <= tgl_next_s;
            out_inv   <= out_next_s;
            div_r     <= tick_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
            // Ready is withheld for exactly the cycle after each accepted request.
            cfg_ready <= ~xfer_s;
            if (xfer_s && chan_bad_s) begin
                cfg_err <= 1'b1;
            end else begin
                cfg_err <= cfg_err;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_hit_s[i]) begin
                    mode_r[i] <= mode_e'(cfg_mode);
                end else begin
                    mode_r[i] <= mode_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_flipper_bank.sv
// Directed self-checking bench for flipper_bank (6 channels, blink divider 4)
// with a cycle-level reference model compared on every falling clock edge.
module tb_flipper_bank;

    localparam int W   = 6;
    localparam int DIV = 4;
    localparam int DW  = 2;
    localparam int CW  = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [W-1:0]  in_true   = 6'h00;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_chan  = 3'd0;
    logic [1:0]    cfg_mode  = 2'd0;
    logic          cfg_ready;
    logic          cfg_err;
    logic [W-1:0]  out_inv;

    int n_tests = 0;
    int n_fail  = 0;

    flipper_bank #(.WIDTH(W), .BLINK_DIV(DIV), .DIV_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_true   (in_true),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .out_inv   (out_inv)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: input sample history, per-channel mode/state, edge count since reset.
    int       mode_m [W];
    bit       t_m [W];
    bit [W-1:0] hist1_m, hist2_m, hist3_m, out_m;
    bit       ready_m, err_m;
    int       edges_m;

    task automatic model_reset();
        for (int c = 0; c < W; c++) begin
            mode_m[c] = 1;
            t_m[c]    = 1'b0;
        end
        hist1_m = '0; hist2_m = '0; hist3_m = '0; out_m = '0;
        ready_m = 1'b1; err_m = 1'b0; edges_m = 0;
    endtask

    task automatic model_step();
        bit tick, xfer, s, p, nt;
        bit [W-1:0] nout;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = ((edges_m % DIV) == DIV - 1);
        xfer = cfg_valid && ready_m;
        nout = '0;
        for (int c = 0; c < W; c++) begin
            s  = hist2_m[c];
            p  = hist3_m[c];
            nt = t_m[c];
            if (mode_m[c] == 2 && s && !p) nt = !nt;
            if (mode_m[c] == 3) nt = s ? (nt ^ tick) : 1'b0;
            if (xfer && int'(cfg_chan) == c) nt = 1'b0;
            if (mode_m[c] == 0)      nout[c] = s;
            else if (mode_m[c] == 1) nout[c] = !s;
            else                     nout[c] = nt;
            t_m[c] = nt;
        end
        if (xfer) begin
            if (int'(cfg_chan) < W) mode_m[int'(cfg_chan)] = int'(cfg_mode);
            else err_m = 1'b1;
        end
        ready_m = !xfer;
        out_m   = nout;
        hist3_m = hist2_m;
        hist2_m = hist1_m;
        hist1_m = in_true;
        edges_m++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model (or reset values while in reset).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("cyc_rst_out",   32'(out_inv),   32'h0);
            check("cyc_rst_ready", 32'(cfg_ready), 32'h1);
            check("cyc_rst_err",   32'(cfg_err),   32'h0);
        end else begin
            check("cyc_out",   32'(out_inv),   32'(out_m));
            check("cyc_ready", 32'(cfg_ready), 32'(ready_m));
            check("cyc_err",   32'(cfg_err),   32'(err_m));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [CW-1:0] chan, input logic [1:0] mode);
        cfg_valid = 1'b1;
        cfg_chan  = chan;
        cfg_mode  = mode;
        step(1);
        cfg_valid = 1'b0;
    endtask

    int   trans, last_k, gap_bad;
    logic prev_b;

    initial begin
        // Reset and INVERT default
        step(3);
        check("reset_out", 32'(out_inv), 32'h00);
        rst_n = 1'b1;
        step(1);
        check("release_all_ones", 32'(out_inv), 32'h3F);
        check("release_ready", 32'(cfg_ready), 32'h1);
        in_true = 6'h1A;
        step(3);
        check("invert_1a", 32'(out_inv), 32'h25);
        in_true = 6'h00;
        step(3);

        // Back-to-back config with valid held: ready 1,0,1,0
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 2'd0;
        check("hs_ready0", 32'(cfg_ready), 32'h1);
        step(1);
        check("hs_ready1", 32'(cfg_ready), 32'h0);
        cfg_chan = 3'd1; cfg_mode = 2'd2;
        step(1);
        check("hs_ready2", 32'(cfg_ready), 32'h1);
        step(1);
        check("hs_ready3", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0;
        step(2);
        check("modes_applied", 32'(out_inv), 32'h3C);
        in_true = 6'h01;
        step(3);
        check("pass_ch0", 32'(out_inv), 32'h3D);

        // Toggle channel 1 with two pulses
        in_true = 6'h03; step(3);
        check("toggle_first", 32'(out_inv[1]), 32'h1);
        in_true = 6'h01; step(3);
        check("toggle_hold", 32'(out_inv[1]), 32'h1);
        in_true = 6'h03; step(3);
        check("toggle_second", 32'(out_inv[1]), 32'h0);
        in_true = 6'h01; step(3);

        // Blink on channel 2: toggles every DIV cycles while held high
        cfg_write(3'd2, 2'd3);
        in_true = 6'h05;
        step(3);
        prev_b = out_inv[2]; trans = 0; last_k = -1; gap_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (out_inv[2] !== prev_b) begin
                if (last_k >= 0 && (k - last_k) != DIV) gap_bad++;
                last_k = k;
                trans++;
            end
            prev_b = out_inv[2];
        end
        check("blink_toggles", 32'(trans), 32'd10);
        check("blink_gap", 32'(gap_bad), 32'd0);
        in_true = 6'h01;
        step(3);
        check("blink_drop", 32'(out_inv[2]), 32'h0);

        // Config write on the same edge as channel 1's synchronised rising edge
        in_true = 6'h03;
        step(2);
        cfg_write(3'd1, 2'd2);
        check("cfg_vs_edge", 32'(out_inv[1]), 32'h0);
        step(2);
        check("cfg_vs_edge_hold", 32'(out_inv[1]), 32'h0);
        in_true = 6'h01;
        step(3);

        // Out-of-range channels set the sticky error and change nothing
        cfg_write(3'd7, 2'd0);
        check("oor_ready", 32'(cfg_ready), 32'h0);
        check("oor_err", 32'(cfg_err), 32'h1);
        step(3);
        check("oor_no_change", 32'(out_inv), 32'h39);
        cfg_write(3'd6, 2'd0);
        step(1);
        cfg_write(3'd3, 2'd0);
        step(2);
        check("later_write", 32'(out_inv), 32'h31);
        check("err_sticky", 32'(cfg_err), 32'h1);

        // Reset mid-blink and mid-handshake
        in_true = 6'h05;
        step(6);
        cfg_valid = 1'b1; cfg_chan = 3'd4; cfg_mode = 2'd0;
        step(1);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("midrst_out", 32'(out_inv), 32'h00);
        check("midrst_ready", 32'(cfg_ready), 32'h1);
        check("midrst_err", 32'(cfg_err), 32'h0);
        step(2);
        in_true = 6'h00;
        rst_n = 1'b1;
        step(1);
        check("rerelease_out", 32'(out_inv), 32'h3F);
        check("rerelease_err", 32'(cfg_err), 32'h0);
        in_true = 6'h3F;
        step(3);
        check("all_invert", 32'(out_inv), 32'h00);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flipper_bank.md
# flipper_bank

Parametrised, registered successor to the single-bit inverter: a bank of `WIDTH` independent channels, each with a run-time-selectable mode (pass, invert, toggle-on-edge, blink). It sits between board switch/button inputs and LED or downstream logic outputs. It synchronises asynchronous inputs, applies each channel's mode and drives registered outputs. Channel modes are written through a valid/ready configuration port.

## Interface
- `WIDTH`, 8: number of channels, 1..32.
- `BLINK_DIV`, 50000: prescaler period in clocks for BLINK mode, ≥2.
- `DIV_W`, 16: prescaler counter width; must satisfy 2^`DIV_W` ≥ `BLINK_DIV`.
- `clk`  in  1: single clock; all state is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_true`  in  `WIDTH`: asynchronous channel inputs.
- `cfg_valid`  in  1: configuration request.
- `cfg_ready`  out  1: configuration port can accept.
- `cfg_chan`  in  max(1,$clog2(`WIDTH`)): target channel.
- `cfg_mode`  in  2: mode encoding, 0=PASS, 1=INVERT, 2=TOGGLE, 3=BLINK.
- `cfg_err`  out  1: sticky flag; set when an accepted request names a channel ≥ `WIDTH`.
- `out_inv`  out  `WIDTH`: registered channel outputs.

## Operation
- Reset values while `rst_n`=0:
  - sync stages = 0, edge-history = 0;
  - all modes = INVERT;
  - toggle state = 0, prescaler = 0;
  - `out_inv` = 0, `cfg_ready` = 1, `cfg_err` = 0.
- Input path: each bit passes through a 2-FF synchroniser, giving `s[i]`. A third register `p[i]` holds the previous `s[i]` for edge detection.
- Per-channel next output:
  - PASS: `s[i]`.
  - INVERT: `~s[i]`.
  - TOGGLE: state `t[i]` flips when `s[i]`=1 and `p[i]`=0 (rising edge). Output is `t[i]`.
  - BLINK: output is 0 while `s[i]`=0, and `t[i]` is cleared. While `s[i]`=1, `t[i]` flips on each prescaler tick. Output is `t[i]`.
- Prescaler: free-running, counts 0..`BLINK_DIV`-1 and wraps to 0. `tick`=1 for exactly the one cycle the count equals `BLINK_DIV`-1. All BLINK channels share it, so they toggle in phase.
- Configuration handshake:
  - A transfer occurs on a cycle with `cfg_valid`=1 and `cfg_ready`=1.
  - The new mode takes effect at that edge, and that channel's `t[i]` is cleared to 0.
  - `cfg_ready` drops to 0 for the one following cycle, then returns to 1. Back-to-back requests therefore take 2 cycles each.
  - `cfg_valid` while `cfg_ready`=0 is ignored. The requester must hold it.
- Out-of-range `cfg_chan` (≥ `WIDTH`): the request is accepted with the normal ready behaviour, no mode changes, and `cfg_err` is set. `cfg_err` clears only on reset.
- Simultaneous events on the same channel in the same cycle:
  - config write vs. edge or tick: the config write wins, `t[i]`=0.
  - edge in TOGGLE mode and tick: the tick is irrelevant to TOGGLE mode.
- Reset mid-operation: everything returns immediately to the reset values above. The prescaler restarts from 0.

## Timing
- Input to output latency is 3 clocks: 2 synchroniser stages plus the output register.
  - PASS/INVERT: a change of `in_true[i]` sampled at edge N appears on `out_inv[i]` after edge N+2.
  - TOGGLE: same latency from the rising edge.
- Mode write accepted at edge N: the new-mode output is visible after edge N+1.
- After reset release with inputs low, `out_inv` goes all-ones after the first edge (INVERT of 0).
- BLINK with input held high: output period is 2·`BLINK_DIV` clocks, 50% duty. The first toggle happens at the next tick, which comes 1..`BLINK_DIV` cycles after the input is seen high.
- No combinational path from inputs to outputs. `cfg_ready` depends only on state.

## Test plan
- Reset, then `in_true`=0x00 → `out_inv`=0x00 during reset, 0xFF from the first cycle after release. Drive 0x5A → `out_inv`=0xA5 three cycles later.
- Write channel 0 = PASS and channel 1 = TOGGLE back-to-back with `cfg_valid` held high → `cfg_ready` pattern 1,0,1,0. Drive in[0]=1 → out[0]=1. Pulse in[1] 0→1→0 twice (each ≥3 cycles) → out[1] goes 1 then 0.
- `BLINK_DIV`=4, channel 2 = BLINK, in[2] held high for 40 cycles → out[2] toggles every 4 cycles. Drop in[2] → out[2]=0 within 3 cycles.
- Write a TOGGLE channel on the same cycle as its synchronised rising edge → mode is updated, `t` cleared, output 0, no flip.
- `WIDTH`=6, write `cfg_chan`=7 → no channel mode changes, `cfg_err`=1 and it stays set. A later valid write still works.
- Assert `rst_n`=0 mid-blink and mid-handshake → all outputs at reset values the same cycle. After release, all channels are INVERT and `cfg_err`=0.
